// File: rtl/crc16_arbiter.sv
// Round-robin arbiter sharing one CRC16 engine among NUM_REQ requesters.
// Optional WAIT_DONE timeout is enabled by defining CRC_ARB_TIMEOUT_EN.
module crc16_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [4*NUM_REQ-1:0]    req_len,
  input  logic [NUM_REQ-1:0]      wr_valid,
  input  logic [16*NUM_REQ-1:0]   wr_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [15:0]             crc_result,
  output logic                    timeout_err,
  output logic                    crc16_start,
  output logic                    crc16_valid,
  output logic [15:0]             data_to_crc,
  input  logic                    crc16_done,
  input  logic [15:0]             data_from_crc,
  output logic                    busy
);
  localparam int unsigned IW       = $clog2(NUM_REQ);
  localparam logic [3:0]  MAX_LEN4 = 4'(MAX_LEN);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT > 127) begin : g_bad_cfg
    $error("crc16_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESP} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gidx_q, gidx_d, last_q, last_d, widx;
  logic               win_found;
  logic [3:0]         len_q, len_d, cnt_q, cnt_d, len_sel;
  logic [15:0]        res_q, res_d, dout_q, dout_d;
  logic               start_q, start_d, valid_q, valid_d;
  logic [3:0]         len_arr [NUM_REQ];
  logic [15:0]        wd_arr  [NUM_REQ];
`ifdef CRC_ARB_TIMEOUT_EN
  localparam logic [6:0] TO7 = 7'(TIMEOUT);
  logic [6:0]         tcnt_q, tcnt_d;
  logic               terr_q, terr_d;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign len_arr[i] = req_len[4*i +: 4];
    assign wd_arr[i]  = wr_data[16*i +: 16];
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    widx      = last_q;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && req[IW'((32'(last_q) + i) % NUM_REQ)]) begin
        widx      = IW'((32'(last_q) + i) % NUM_REQ);
        win_found = 1'b1;
      end
    end
    len_sel = (len_arr[widx] > MAX_LEN4) ? MAX_LEN4 : len_arr[widx];
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      start_q <= start_d;
      valid_q <= valid_d;
`ifdef CRC_ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dout_d  = dout_q;
    start_d = 1'b0;
    valid_d = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d       = '0;
          gnt_d[widx] = 1'b1;
          gidx_d      = widx;
          len_d       = len_sel;
          cnt_d       = '0;
`ifdef CRC_ARB_TIMEOUT_EN
          terr_d      = 1'b0;
`endif
          if (len_sel == 4'd0) begin
            state_d = RESP;
            res_d   = '0;
          end else begin
            state_d = STREAM;
            start_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (wr_valid[gidx_q]) begin
          dout_d  = wd_arr[gidx_q];
          valid_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == len_q) begin
            state_d = WAIT_DONE;
`ifdef CRC_ARB_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      WAIT_DONE: begin
        if (crc16_done) begin
          res_d   = data_from_crc;
          state_d = RESP;
        end
`ifdef CRC_ARB_TIMEOUT_EN
        else if (tcnt_q == TO7) begin
          res_d   = '1;
          terr_d  = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_q + 7'd1;
        end
`endif
      end
      RESP: begin
        last_d  = gidx_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt         = gnt_q;
    done        = (state_q == RESP) ? gnt_q : '0;
    crc_result  = res_q;
    crc16_start = start_q;
    crc16_valid = valid_q;
    data_to_crc = dout_q;
    busy        = (state_q != IDLE);
`ifdef CRC_ARB_TIMEOUT_EN
    timeout_err = (state_q == RESP) && terr_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_crc16_arbiter.sv
// Scoreboard bench for crc16_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares grants, forwarded words and completions.
module tb_crc16_arbiter;
  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic [3:0]  req    = '0;
  logic [15:0] req_len;
  logic [3:0]  wr_valid = '0;
  logic [63:0] wr_data  = '0;
  logic [3:0]  gnt, done;
  logic [15:0] crc_result, data_to_crc;
  logic        timeout_err, crc16_start, crc16_valid, busy;
  logic        crc16_done    = 1'b0;
  logic [15:0] data_from_crc = '0;

  logic [3:0]  len_tab [4];
  logic [15:0] wbase   [4];
  logic [15:0] rtab    [4];

  typedef struct { int idx; bit start; } gexp_t;
  typedef struct { logic [3:0] d; logic [15:0] r; logic t; } dexp_t;
  gexp_t       exp_gnt[$];
  logic [15:0] exp_word[$];
  dexp_t       exp_done[$];

  int tests = 0, fails = 0, n_start = 0, exp_starts = 0;
  logic [3:0] prev_gnt = '0;

  crc16_arbiter #(.NUM_REQ(4), .MAX_LEN(8), .TIMEOUT(64)) dut (
    .clk_in(clk_in), .rst(rst), .req(req), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .gnt(gnt), .done(done),
    .crc_result(crc_result), .timeout_err(timeout_err),
    .crc16_start(crc16_start), .crc16_valid(crc16_valid),
    .data_to_crc(data_to_crc), .crc16_done(crc16_done),
    .data_from_crc(data_from_crc), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always_comb for (int i = 0; i < 4; i++) req_len[4*i +: 4] = len_tab[i];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_grant(input int idx, input bit start);
    exp_gnt.push_back('{idx, start});
    if (start) exp_starts++;
  endfunction

  always @(negedge clk_in) begin
    if (rst) begin
      prev_gnt = '0;
    end else begin
      gexp_t ge;
      dexp_t de;
      logic [15:0] we;
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (gnt != 0 && prev_gnt == 0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
        else begin
          ge = exp_gnt.pop_front();
          chk("gnt_order", 64'(gnt), 64'(4'b0001 << ge.idx));
          chk("start_at_grant", 64'(crc16_start), 64'(ge.start));
        end
      end
      if (crc16_start) n_start++;
      if (crc16_valid) begin
        if (exp_word.size() == 0) chk("word_unexpected", 64'(data_to_crc), 64'hFFFF_FFFF);
        else begin
          we = exp_word.pop_front();
          chk("data_to_crc", 64'(data_to_crc), 64'(we));
        end
      end
      if (done != 0) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          de = exp_done.pop_front();
          chk("done_vec", 64'(done), 64'(de.d));
          chk("crc_result", 64'(crc_result), 64'(de.r));
          chk("timeout_err", 64'(timeout_err), 64'(de.t));
          chk("gnt_with_done", 64'(gnt), 64'(done));
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic rst_pulse();
    @(negedge clk_in);
    rst = 1'b1; req = '0; wr_valid = '0; crc16_done = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int g);
    bit got = 0;
    g = -1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_in);
      if (gnt != 0) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL grant_wait: no grant within 50 cycles");
    end else
      for (int i = 0; i < 4; i++) if (gnt[i]) g = i;
  endtask

  // Serve one grant; returns #1 after the RESP->IDLE edge when the engine replies.
  task automatic serve(input bit drop_req, input bit engine_resp);
    int g, nw;
    bit got;
    wait_grant(g);
    if (g < 0) return;
    if (drop_req) req[g] = 1'b0;
    nw = (len_tab[g] > 4'd8) ? 8 : int'(len_tab[g]);
    for (int k = 0; k < nw; k++) begin
      wr_valid[g] = 1'b1;
      wr_data[16*g +: 16] = wbase[g] + 16'(k);
      @(posedge clk_in); #1;
    end
    if (nw > 0) begin
      wr_data[16*g +: 16] = 16'h0BAD;
      if (engine_resp) begin
        crc16_done = 1'b1; data_from_crc = rtab[g];
        @(posedge clk_in); #1;
        crc16_done = 1'b0;
      end
      wr_valid[g] = 1'b0;
    end
    if (engine_resp || nw == 0) begin
      got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
        if (done != 0) got = 1;
        else @(negedge clk_in);
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL done_wait: no done within 50 cycles");
      end
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin len_tab[i] = '0; wbase[i] = '0; rtab[i] = '0; end

    // Reset state
    @(posedge clk_in); @(posedge clk_in); #1;
    chk("reset_outputs", {gnt, done, crc_result, timeout_err, crc16_start, crc16_valid, data_to_crc, busy}, '0);
    @(negedge clk_in); rst = 1'b0;

    // Eight-word transaction on requester 0, req dropped after grant
    len_tab[0] = 4'd8; wbase[0] = 16'h0001; rtab[0] = 16'hBEEF;
    push_grant(0, 1);
    for (int k = 0; k < 8; k++) exp_word.push_back(16'h0001 + 16'(k));
    exp_done.push_back('{4'b0001, 16'hBEEF, 1'b0});
    req[0] = 1'b1;
    serve(1, 1);

    // All four requesting, len=1 each: order 0,1,2,3,0 after reset
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      len_tab[i] = 4'd1; wbase[i] = 16'h1000 + 16'(i); rtab[i] = 16'hA000 + 16'(i);
    end
    for (int t = 0; t < 5; t++) begin
      push_grant(t % 4, 1);
      exp_word.push_back(16'h1000 + 16'(t % 4));
      exp_done.push_back('{4'b0001 << (t % 4), 16'hA000 + 16'(t % 4), 1'b0});
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) serve(0, 1);
    req = '0;

    // Zero-length request on requester 2: no start, no words, result 0
    len_tab[2] = 4'd0;
    push_grant(2, 0);
    exp_done.push_back('{4'b0100, 16'h0000, 1'b0});
    req[2] = 1'b1;
    serve(1, 1);

    // Requester 1 streams 3 words while requester 0 strobes 16'hDEAD
    len_tab[1] = 4'd3; wbase[1] = 16'h3001; rtab[1] = 16'h5A5A;
    push_grant(1, 1);
    for (int k = 0; k < 3; k++) exp_word.push_back(16'h3001 + 16'(k));
    exp_done.push_back('{4'b0010, 16'h5A5A, 1'b0});
    wr_valid[0] = 1'b1; wr_data[15:0] = 16'hDEAD;
    req[1] = 1'b1;
    serve(1, 1);
    wr_valid[0] = 1'b0;

    // Reset after 2 of 5 words; then requesters 0 and 2 ask, 0 must win
    len_tab[0] = 4'd5; wbase[0] = 16'h4001;
    push_grant(0, 1);
    exp_word.push_back(16'h4001); exp_word.push_back(16'h4002);
    req[0] = 1'b1;
    wait_grant(n);
    wr_valid[0] = 1'b1; wr_data[15:0] = 16'h4001;
    @(posedge clk_in); #1;
    wr_data[15:0] = 16'h4002;
    @(posedge clk_in); #1;
    wr_valid[0] = 1'b0;
    @(negedge clk_in); #1;
    rst = 1'b1; req = '0;
    #1;
    chk("async_reset_outputs", {gnt, done, crc_result, timeout_err, crc16_start, crc16_valid, data_to_crc, busy}, '0);
    len_tab[0] = 4'd1; wbase[0] = 16'h5000; rtab[0] = 16'h5100;
    len_tab[2] = 4'd1; wbase[2] = 16'h5200; rtab[2] = 16'h5300;
    push_grant(0, 1); exp_word.push_back(16'h5000); exp_done.push_back('{4'b0001, 16'h5100, 1'b0});
    push_grant(2, 1); exp_word.push_back(16'h5200); exp_done.push_back('{4'b0100, 16'h5300, 1'b0});
    @(negedge clk_in);
    req = 4'b0101;
    rst = 1'b0;
    serve(1, 1);
    serve(1, 1);

    // Engine never answers requester 3
    len_tab[3] = 4'd1; wbase[3] = 16'h6000;
    push_grant(3, 1); exp_word.push_back(16'h6000);
`ifdef CRC_ARB_TIMEOUT_EN
    exp_done.push_back('{4'b1000, 16'hFFFF, 1'b1});
`endif
    req[3] = 1'b1;
    serve(1, 0);
    for (n = 0; n < 100 && done == 0; n++) begin @(posedge clk_in); #1; end
`ifdef CRC_ARB_TIMEOUT_EN
    chk("timeout_latency", 64'(n), 64'd65);
    @(posedge clk_in); #1;
`else
    chk("no_done_without_engine", 64'(n), 64'd100);
    chk("busy_waiting", 64'(busy), 64'd1);
    rst_pulse();
`endif

    // len=15 saturates to MAX_LEN=8 on requester 1
    len_tab[1] = 4'd15; wbase[1] = 16'h7000; rtab[1] = 16'h7777;
    push_grant(1, 1);
    for (int k = 0; k < 8; k++) exp_word.push_back(16'h7000 + 16'(k));
    exp_done.push_back('{4'b0010, 16'h7777, 1'b0});
    req[1] = 1'b1;
    serve(1, 1);

    repeat (3) @(negedge clk_in);
    #1;
    chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
    chk("word_queue_empty", 64'(exp_word.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    chk("start_pulses", 64'(n_start), 64'(exp_starts));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/crc16_arbiter.md
# crc16_arbiter

Round-robin controller that shares one CRC16 engine among `NUM_REQ` frame-parser requesters. It grants the engine to one requester at a time and issues the engine start pulse. It forwards the granted requester's 16-bit words to the engine and returns the engine result with a one-cycle completion pulse. It sits between the per-channel frame parsers and the single CRC16 calculator in the receive path.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_LEN`, 8: maximum words per transaction; 128-bit payload / 16.
- `TIMEOUT`, 64: cycles to wait for `crc16_done` (used only with the timeout feature).

Ports:
- `clk_in` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester request level. The requester holds it until its `done`.
- `req_len` in 4*NUM_REQ: word count per requester, slice i = [4i+3:4i]. Sampled at grant.
- `wr_valid` in NUM_REQ: per-requester word strobe.
- `wr_data` in 16*NUM_REQ: per-requester word, slice i = [16i+15:16i].
- `gnt` out NUM_REQ: one-hot grant, registered.
- `done` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `crc_result` out 16: engine result. Valid while `done` is non-zero, held until the next `done`.
- `timeout_err` out 1: high with `done` when the transaction was aborted by timeout.
- `crc16_start` out 1: one-cycle pulse that clears the engine before a transaction.
- `crc16_valid` out 1: word strobe to the engine.
- `data_to_crc` out 16: word to the engine.
- `crc16_done` in 1: engine completion.
- `data_from_crc` in 16: engine result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
States and transitions:
- **IDLE**. When any `req` bit is set, the arbiter picks the winner by round-robin.
  - Search starts at `last+1` modulo `NUM_REQ`, where `last` is the previous winner. `last` resets to `NUM_REQ-1`, so requester 0 wins first after reset.
  - Latched on the transition: `gnt`, `len` (4 bits from `req_len`), and word counter `cnt` = 0.
  - A latched `len` > `MAX_LEN` saturates to `MAX_LEN`.
  - Non-zero `len` → STREAM, with `crc16_start` = 1 for exactly one cycle (the first STREAM cycle).
  - `len` = 0 → RESP directly. The engine is not touched and `crc_result` = 16'h0000.
- **STREAM**. Each cycle that `wr_valid[g]` is high, the arbiter registers `wr_data[g]` onto `data_to_crc` with `crc16_valid` = 1 and increments `cnt`.
  - `wr_valid` from non-granted requesters is ignored.
  - When the word taking `cnt` to `len` is accepted, state → WAIT_DONE.
  - `crc16_done` seen in STREAM is ignored.
- **WAIT_DONE**. On `crc16_done` = 1, latch `crc_result` ← `data_from_crc` and go to RESP.
- **RESP**. Lasts one cycle.
  - `done[g]` = 1 and `gnt` is still asserted.
  - `last` ← g.
  - Next cycle: `gnt` = 0, `done` = 0, state → IDLE.

Boundary conditions:
- Simultaneous requests: round-robin guarantees each active requester is served within `NUM_REQ` transactions.
- `req[g]` dropping mid-transaction has no effect; the transaction completes.
- The arbiter sends no words past `len`; extra `wr_valid[g]` in WAIT_DONE or RESP is ignored.
- Reset at any point aborts the transaction with no `done` pulse. The engine is re-cleared by the next `crc16_start`.

Reset values: all outputs 0, state IDLE, `crc_result` 16'h0000, `last` = `NUM_REQ-1`.

## Timing
- `req` sampled high in IDLE at edge N → `gnt` and `busy` high at N+1, `crc16_start` high N+1 only.
- Word accepted (`wr_valid[g]`) at edge M → `crc16_valid`/`data_to_crc` at M+1, one-cycle forward latency. Full throughput of one word per cycle.
- `crc16_done` sampled at edge K → `done[g]`, `crc_result` valid at K+1. `gnt` low at K+2.
- Earliest next grant: IDLE at K+2, `gnt` at K+3.
- Back-to-back transactions therefore leave a minimum 1-cycle IDLE gap.

## Configuration
- `CRC_ARB_TIMEOUT_EN` defined:
  - A 7-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - When it reaches `TIMEOUT` with no `crc16_done`, the arbiter goes to RESP with `crc_result` = 16'hFFFF and `timeout_err` = 1 alongside `done[g]`.
  - A `crc16_done` arriving in the same cycle as the timeout wins, giving a normal completion.
- Undefined: no counter, WAIT_DONE waits indefinitely, and `timeout_err` is tied 0.

## Test plan
- Reset, then `req`=4'b0001, `len`=8, eight words 16'h0001..16'h0008 on consecutive cycles, engine returns 16'hBEEF → one `crc16_start`, eight `crc16_valid` in order, `done`=4'b0001, `crc_result`=16'hBEEF.
- `req`=4'b1111 held, every transaction `len`=1 → grant order 0,1,2,3,0; each `gnt` one-hot; never two grants overlapping.
- Requester 2 has `len`=0 → `done[2]` with `crc_result`=16'h0000, no `crc16_start`, no `crc16_valid`.
- Granted requester 1 streams `len`=3 while requester 0 pulses `wr_valid` with 16'hDEAD → 16'hDEAD never appears on `data_to_crc`; exactly 3 words forwarded.
- `rst` asserted mid-STREAM after 2 of 5 words → all outputs 0 immediately, no `done`; next request regranted from requester 0.
- With `CRC_ARB_TIMEOUT_EN`, `TIMEOUT`=64 and `crc16_done` withheld → `done[g]` 65 cycles after WAIT_DONE entry, `timeout_err`=1, `crc_result`=16'hFFFF.
